// File: rtl/mc_ctrl_seq_if.sv
// Control bus between the multi-cycle sequencer and the single-cycle datapath.
// The sequencer side takes the master modport; the datapath side takes the slave modport.
interface mc_ctrl_seq_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr_in;
    logic             zero;
    logic [31:0]      ir;
    logic             pc_we;
    logic [1:0]       npc_sel;
    logic             grf_we;
    logic [1:0]       a3_sel;
    logic [1:0]       wd_sel;
    logic [2:0]       alu_sel;
    logic             alu_b_sel;
    logic             ext_type;
    logic             dm_we;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
    logic             illegal;

    modport master (
        input  instr_in, zero,
        output ir, pc_we, npc_sel, grf_we, a3_sel, wd_sel, alu_sel,
               alu_b_sel, ext_type, dm_we, state, retired, illegal
    );

    modport slave (
        output instr_in, zero,
        input  ir, pc_we, npc_sel, grf_we, a3_sel, wd_sel, alu_sel,
               alu_b_sel, ext_type, dm_we, state, retired, illegal
    );
endinterface

// File: rtl/mc_ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the single-cycle datapath.
// Selects decode straight from ir; only the PC/GRF/DM write enables depend on the state.
module mc_ctrl_seq #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          reset,
    mc_ctrl_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADDU, OP_SUBU, OP_JR, OP_ORI, OP_LUI,
        OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_BAD
    } op_e;

    state_e           state_q, state_d;
    logic [31:0]      ir_q;
    logic [3:0]       wait_q;
    logic [CNT_W-1:0] retired_q;
    op_e              op;
    logic             pc_we, grf_we, dm_we;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        op = OP_BAD;
        if (ir_q == 32'd0) begin
            op = OP_NOP;
        end else begin
            case (ir_q[31:26])
                6'h00: begin
                    case (ir_q[5:0])
                        6'h21:   op = OP_ADDU;
                        6'h23:   op = OP_SUBU;
                        6'h08:   op = OP_JR;
                        default: op = OP_BAD;
                    endcase
                end
                6'h0D:   op = OP_ORI;
                6'h0F:   op = OP_LUI;
                6'h23:   op = OP_LW;
                6'h2B:   op = OP_SW;
                6'h04:   op = OP_BEQ;
                6'h03:   op = OP_JAL;
                default: op = OP_BAD;
            endcase
        end
    end

    // Datapath selects are pure functions of ir, valid in every state.
    always_comb begin
        bus.npc_sel   = 2'd0;
        bus.a3_sel    = 2'd0;
        bus.wd_sel    = 2'd0;
        bus.alu_sel   = 3'd0;
        bus.alu_b_sel = 1'b0;
        bus.ext_type  = 1'b0;
        case (op)
            OP_ADDU: bus.a3_sel = 2'd1;
            OP_SUBU: begin bus.a3_sel = 2'd1; bus.alu_sel = 3'd1; end
            OP_JR:   bus.npc_sel = 2'd3;
            OP_ORI:  begin bus.alu_sel = 3'd2; bus.alu_b_sel = 1'b1; end
            OP_LUI:  begin bus.alu_sel = 3'd3; bus.alu_b_sel = 1'b1; end
            OP_LW:   begin bus.wd_sel = 2'd1; bus.alu_b_sel = 1'b1; bus.ext_type = 1'b1; end
            OP_SW:   begin bus.alu_b_sel = 1'b1; bus.ext_type = 1'b1; end
            OP_BEQ:  begin
                bus.alu_sel  = 3'd1;
                bus.ext_type = 1'b1;
                bus.npc_sel  = bus.zero ? 2'd1 : 2'd0;
            end
            OP_JAL:  begin bus.npc_sel = 2'd2; bus.a3_sel = 2'd2; bus.wd_sel = 2'd2; end
            default: ;
        endcase
    end

    // pc_we marks each instruction's final state, so it doubles as the retire strobe.
    always_comb begin
        state_d = state_q;
        pc_we   = 1'b0;
        grf_we  = 1'b0;
        dm_we   = 1'b0;
        unique case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_NOP, OP_JR: begin pc_we = 1'b1; state_d = S_FETCH; end
                    OP_JAL:  begin pc_we = 1'b1; grf_we = 1'b1; state_d = S_FETCH; end
                    OP_BAD:  state_d = S_TRAP;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (op)
                    OP_BEQ:       begin pc_we = 1'b1; state_d = S_FETCH; end
                    OP_LW, OP_SW: state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (wait_q == 4'd0) begin
                    if (op == OP_SW) begin
                        dm_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                grf_we  = 1'b1;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= 32'd0;
            wait_q    <= 4'd0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH)
                ir_q <= bus.instr_in;
            if (state_q == S_EXEC)
                wait_q <= 4'(MEM_WAIT);
            else if (state_q == S_MEM && wait_q != 4'd0)
                wait_q <= wait_q - 4'd1;
            if (pc_we)
                retired_q <= retired_q + 1'b1;
        end
    end

    assign bus.ir      = ir_q;
    assign bus.pc_we   = pc_we;
    assign bus.grf_we  = grf_we;
    assign bus.dm_we   = dm_we;
    assign bus.state   = state_q;
    assign bus.retired = retired_q;
    assign bus.illegal = (state_q == S_TRAP);
endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Randomized self-checking bench for mc_ctrl_seq against an instruction-level reference model.
// The model derives state sequence, enables and selects from the instruction class alone.
module tb_mc_ctrl_seq;
    localparam int MW    = 2;
    localparam int CNT_W = 4;

    typedef enum int {
        K_NOP, K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_ILL
    } kind_e;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_ret = 0;

    mc_ctrl_seq_if #(.CNT_W(CNT_W)) bus ();

    mc_ctrl_seq #(.MEM_WAIT(MW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic kind_e classify(input logic [31:0] w);
        logic [5:0] opc, fn;
        opc = w[31:26];
        fn  = w[5:0];
        if (w == 32'd0) return K_NOP;
        case (opc)
            6'h00:   return (fn == 6'h21) ? K_ADDU : (fn == 6'h23) ? K_SUBU :
                            (fn == 6'h08) ? K_JR : K_ILL;
            6'h0D:   return K_ORI;
            6'h0F:   return K_LUI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h03:   return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [31:0] make_instr(input kind_e k);
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        imm = 16'($urandom);
        case (k)
            K_ADDU:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            K_SUBU:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
            K_JR:    return {6'h00, rs, 15'd0, 6'h08};
            K_ORI:   return {6'h0D, rs, rt, imm};
            K_LUI:   return {6'h0F, 5'd0, rt, imm};
            K_LW:    return {6'h23, rs, rt, imm};
            K_SW:    return {6'h2B, rs, rt, imm};
            K_BEQ:   return {6'h04, rs, rt, imm};
            K_JAL:   return {6'h03, 26'($urandom)};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_selects(input kind_e k, input logic z);
        logic [1:0] e_npc, e_a3, e_wd;
        logic [2:0] e_alu;
        e_npc = (k == K_JAL) ? 2'd2 : (k == K_JR) ? 2'd3 : (k == K_BEQ && z) ? 2'd1 : 2'd0;
        check("npc_sel", 32'(bus.npc_sel), 32'(e_npc));
        check("alu_b_sel", 32'(bus.alu_b_sel), 32'(k inside {K_ORI, K_LUI, K_LW, K_SW}));
        check("ext_type", 32'(bus.ext_type), 32'(k inside {K_LW, K_SW, K_BEQ}));
        if (k inside {K_JAL, K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW}) begin
            e_a3 = (k == K_JAL) ? 2'd2 : (k inside {K_ADDU, K_SUBU}) ? 2'd1 : 2'd0;
            e_wd = (k == K_JAL) ? 2'd2 : (k == K_LW) ? 2'd1 : 2'd0;
            check("a3_sel", 32'(bus.a3_sel), 32'(e_a3));
            check("wd_sel", 32'(bus.wd_sel), 32'(e_wd));
        end
        if (!(k inside {K_NOP, K_JAL, K_JR})) begin
            e_alu = (k inside {K_SUBU, K_BEQ}) ? 3'd1 : (k == K_ORI) ? 3'd2 :
                    (k == K_LUI) ? 3'd3 : 3'd0;
            check("alu_sel", 32'(bus.alu_sel), 32'(e_alu));
        end
    endtask

    // Entered on a negedge with the DUT in FETCH; leaves on the negedge of the next FETCH.
    task automatic run_instr(input logic [31:0] word, input logic z);
        kind_e k;
        int    st[$];
        bit    writes_grf, last;
        k  = classify(word);
        st = {0, 1};
        case (k)
            K_BEQ: st.push_back(2);
            K_ADDU, K_SUBU, K_ORI, K_LUI: begin st.push_back(2); st.push_back(4); end
            K_LW, K_SW: begin
                st.push_back(2);
                for (int i = 0; i <= MW; i++) st.push_back(3);
                if (k == K_LW) st.push_back(4);
            end
            default: ;
        endcase
        writes_grf = k inside {K_JAL, K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW};
        bus.instr_in = word;
        bus.zero     = z;
        for (int c = 0; c < st.size(); c++) begin
            if (c > 0) @(negedge clk);
            #1;
            last = (c == st.size() - 1) && (k != K_ILL);
            if (c == 0) begin
                check("retired", 32'(bus.retired), 32'(model_ret));
                check("illegal_clear", 32'(bus.illegal), 32'd0);
            end else begin
                check("ir", bus.ir, word);
            end
            check("state", 32'(bus.state), 32'(st[c]));
            check("pc_we", 32'(bus.pc_we), 32'(last));
            check("grf_we", 32'(bus.grf_we), 32'(last && writes_grf));
            check("dm_we", 32'(bus.dm_we), 32'(last && k == K_SW));
            if (last) check_selects(k, z);
        end
        if (k != K_ILL) model_ret = (model_ret + 1) % (1 << CNT_W);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        #1;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_retired", 32'(bus.retired), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        check("rst_ir", bus.ir, 32'd0);
        check("rst_enables", 32'({bus.pc_we, bus.grf_we, bus.dm_we}), 32'd0);
        check("rst_selects", 32'({bus.npc_sel, bus.a3_sel, bus.wd_sel, bus.alu_sel,
                                  bus.alu_b_sel, bus.ext_type}), 32'd0);
        reset = 1'b0;
        model_ret = 0;
    endtask

    initial begin
        bus.instr_in = 32'd0;
        bus.zero     = 1'b0;
        @(negedge clk);
        reset_dut();

        run_instr(32'h3401_1234, 1'b0);   // ori $1,$0,0x1234
        run_instr(32'h1000_0003, 1'b1);   // beq taken
        run_instr(32'h1000_0003, 1'b0);   // beq not taken
        run_instr(32'hAC01_0004, 1'b0);   // sw
        run_instr(32'h8C02_0004, 1'b0);   // lw
        run_instr(32'h0C00_0010, 1'b0);   // jal
        run_instr(32'h0000_0000, 1'b1);   // nop

        for (int i = 0; i < 40; i++)
            run_instr(make_instr(kind_e'($urandom_range(0, 9))), 1'($urandom));

        // Abort an addu in EXEC: nothing may be written and the count clears at once.
        bus.instr_in = make_instr(K_ADDU);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("abort_state_exec", 32'(bus.state), 32'd2);
        reset = 1'b1;
        #1;
        check("abort_state", 32'(bus.state), 32'd0);
        check("abort_retired", 32'(bus.retired), 32'd0);
        check("abort_grf_we", 32'(bus.grf_we), 32'd0);
        check("abort_pc_we", 32'(bus.pc_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_ret = 0;
        run_instr(make_instr(K_SUBU), 1'b0);

        run_instr(32'hFC00_0000, 1'b0);   // opcode 0x3F
        for (int i = 0; i < 10; i++) begin
            #1;
            check("trap_state", 32'(bus.state), 32'd7);
            check("trap_illegal", 32'(bus.illegal), 32'd1);
            check("trap_enables", 32'({bus.pc_we, bus.grf_we, bus.dm_we}), 32'd0);
            @(negedge clk);
        end
        reset_dut();
        run_instr(32'h3401_1234, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
